alu_share_arbiter: RTL and testbench



---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_share_arbiter_rr_arb2.sv | 21 ++
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Opcode map and FSM encoding shared by the ALU arbiter and its helpers.
// Only the seven opcodes listed here are implemented by the downstream ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;
    localparam logic [3:0] ALU_SLL = 4'd13;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    // Takes a zero-extended opcode so callers with any OPW <= 32 can use it.
    function automatic logic op_is_legal(input logic [31:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            32'(ALU_AND), 32'(ALU_OR), 32'(ALU_ADD), 32'(ALU_SUB),
            32'(ALU_SLT), 32'(ALU_NOR), 32'(ALU_SLL): legal = 1'b1;
            default: legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to prio.
// Purely combinational; the prio register lives in the parent.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = 1'b0;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = prio;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between the datapath (req0) and the branch unit (req1).
// One operation is in flight at a time; its result is registered and held until acknowledged.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [OPW-1:0]   req0_op,
    input  logic [OPW-1:0]   req1_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [4:0]       req0_shamt,
    input  logic [4:0]       req1_shamt,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic [OPW-1:0]   alu_ctrl,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output state_e           dbg_state,
    output logic             dbg_prio
);

    // Handshakes: a transfer happens on a clock edge where valid and ready are both high.
    // req_ready depends only on req_valid, registered state and reset (never on rsp_ready);
    // rsp_valid[g] stays high with rsp_* frozen until rsp_ready[g], other rsp_ready bit ignored.

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    logic             owner_q, owner_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_zero_q, rsp_zero_d;
    logic             rsp_err_q, rsp_err_d;

    logic gnt_valid;
    logic gnt_idx;
    logic gnt_go;

    rr_arb2 u_arb (
        .req       (req_valid),
        .prio      (prio_q),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign gnt_go = (state_q == ST_IDLE) && gnt_valid && !reset;

    always_comb begin
        alu_ctrl  = '0;
        alu_a     = '0;
        alu_b     = '0;
        alu_shamt = '0;
        req_ready = 2'b00;
        if (gnt_go) begin
            if (gnt_idx) begin
                alu_ctrl  = req1_op;
                alu_a     = req1_a;
                alu_b     = req1_b;
                alu_shamt = req1_shamt;
                req_ready = 2'b10;
            end else begin
                alu_ctrl  = req0_op;
                alu_a     = req0_a;
                alu_b     = req0_b;
                alu_shamt = req0_shamt;
                req_ready = 2'b01;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        owner_d      = owner_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_go) begin
                    rsp_result_d = alu_result;
                    rsp_zero_d   = alu_zero;
                    // Illegal ops still run through the ALU; only the flag marks them.
                    rsp_err_d    = !op_is_legal(32'(alu_ctrl));
                    rsp_valid_d  = gnt_idx ? 2'b10 : 2'b01;
                    prio_d       = ~gnt_idx;
                    owner_d      = gnt_idx;
                    state_d      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            prio_q       <= 1'b0;
            owner_q      <= 1'b0;
            rsp_valid_q  <= 2'b00;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            owner_q      <= owner_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_err    = rsp_err_q;
    assign dbg_state  = state_q;
    assign dbg_prio   = prio_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a behavioural ALU hangs off the alu_* ports and a
// scoreboard queue holds {requester, err, zero, result} for every granted request.
module tb_alu_share_arbiter;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int OPW   = 4;
    localparam int W     = WIDTH + 3;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req_valid, req_ready, rsp_valid, rsp_ready;
    logic [OPW-1:0]   req0_op, req1_op, alu_ctrl;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]       req0_shamt, req1_shamt, alu_shamt;
    logic [WIDTH-1:0] rsp_result, alu_a, alu_b, alu_result;
    logic             rsp_zero, rsp_err, alu_zero, dbg_prio;
    state_e           dbg_state;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    alu_share_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req0_op(req0_op), .req1_op(req1_op),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .dbg_state(dbg_state), .dbg_prio(dbg_prio)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b, input logic [4:0] sh);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd2:    return a + b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? WIDTH'(1) : '0;
            4'd12:   return ~(a | b);
            4'd13:   return b << sh;
            default: return '0;
        endcase
    endfunction

    function automatic logic bench_legal(input logic [3:0] op);
        return op inside {4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13};
    endfunction

    always_comb begin
        alu_result = alu_fn(alu_ctrl, alu_a, alu_b, alu_shamt);
        alu_zero   = (alu_result == '0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic idx, input logic [3:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [4:0] sh);
        if (idx) begin
            req1_op = op; req1_a = a; req1_b = b; req1_shamt = sh;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_shamt = sh;
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        tick();
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; rsp_ready = 2'b00;
        set_req(0, 4'd2, 32'd1, 32'd1, 5'd0);
        set_req(1, 4'd2, 32'd1, 32'd1, 5'd0);
        req_valid = 2'b11;
        tick(); tick();
        n_checks++; if (rsp_valid !== 2'b00) $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); else n_pass++;
        n_checks++; if ({rsp_result, rsp_zero, rsp_err} !== {32'd0, 1'b0, 1'b0}) $display("FAIL reset_rsp_data got=%h/%b/%b exp=0/0/0", rsp_result, rsp_zero, rsp_err); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE || dbg_prio !== 1'b0) $display("FAIL reset_state got=%b/%b exp=IDLE/0", dbg_state, dbg_prio); else n_pass++;
        n_checks++; if (req_ready !== 2'b00) $display("FAIL reset_req_ready got=%b exp=00", req_ready); else n_pass++;
        req_valid = 2'b00; reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_single();
        logic [W-1:0] e;
        set_req(0, 4'd2, 32'd5, 32'd7, 5'd0);
        req_valid = 2'b01; #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL single_ready got=%b exp=01", req_ready); else n_pass++;
        n_checks++; if ({alu_ctrl, alu_a, alu_b} !== {4'd2, 32'd5, 32'd7}) $display("FAIL single_alu_in got=%h/%h/%h exp=2/5/7", alu_ctrl, alu_a, alu_b); else n_pass++;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd12});
        tick();
        req_valid = 2'b10; #1;
        n_checks++; if (rsp_valid !== 2'b01) $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); else n_pass++;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL single_sb queue empty");
        else begin
            e = exp_q.pop_front();
            if ({rsp_valid[1], rsp_err, rsp_zero, rsp_result} !== e) $display("FAIL single_rsp got=%h exp=%h", {rsp_valid[1], rsp_err, rsp_zero, rsp_result}, e); else n_pass++;
        end
        n_checks++; if ({req_ready, alu_ctrl, alu_a} !== {2'b00, 4'd0, 32'd0}) $display("FAIL single_resp_idle_bus got=%b/%h/%h exp=00/0/0", req_ready, alu_ctrl, alu_a); else n_pass++;
        req_valid = 2'b00; rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        n_checks++; if (rsp_valid !== 2'b00 || dbg_state !== ST_IDLE) $display("FAIL single_ack got=%b/%b exp=00/IDLE", rsp_valid, dbg_state); else n_pass++;
        n_checks++; if (rsp_result !== 32'd12) $display("FAIL single_retain got=%h exp=c", rsp_result); else n_pass++;
    endtask

    task automatic test_contention();
        logic [W-1:0] e;
        logic         g;
        pulse_reset();
        set_req(0, 4'd6, 32'd9, 32'd9, 5'd0);
        set_req(1, 4'd7, 32'd3, 32'd4, 5'd0);
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            g = k[0];
            #1;
            n_checks++; if (req_ready !== (g ? 2'b10 : 2'b01)) $display("FAIL contention_grant%0d got=%b exp=%b", k, req_ready, g ? 2'b10 : 2'b01); else n_pass++;
            exp_q.push_back(g ? {1'b1, 1'b0, 1'b0, 32'd1} : {1'b0, 1'b0, 1'b1, 32'd0});
            tick();
            n_checks++; if (rsp_valid !== (g ? 2'b10 : 2'b01)) $display("FAIL contention_route%0d got=%b exp=%b", k, rsp_valid, g ? 2'b10 : 2'b01); else n_pass++;
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL contention_sb queue empty");
            else begin
                e = exp_q.pop_front();
                if ({rsp_valid[1], rsp_err, rsp_zero, rsp_result} !== e) $display("FAIL contention_rsp%0d got=%h exp=%h", k, {rsp_valid[1], rsp_err, rsp_zero, rsp_result}, e); else n_pass++;
            end
            rsp_ready = 2'b11;
            tick();
            rsp_ready = 2'b00;
        end
        req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] e;
        set_req(1, 4'd13, 32'd0, 32'd1, 5'd4);
        req_valid = 2'b10; #1;
        n_checks++; if (req_ready !== 2'b10 || alu_shamt !== 5'd4) $display("FAIL bp_grant got=%b/%0d exp=10/4", req_ready, alu_shamt); else n_pass++;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'd16});
        tick();
        set_req(0, 4'd2, 32'd1, 32'd1, 5'd0);
        req_valid = 2'b01;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++; if ({rsp_valid, rsp_result} !== {2'b10, 32'd16}) $display("FAIL bp_hold%0d got=%b/%h exp=10/10", k, rsp_valid, rsp_result); else n_pass++;
            n_checks++; if (req_ready !== 2'b00) $display("FAIL bp_ready%0d got=%b exp=00", k, req_ready); else n_pass++;
            tick();
        end
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_sb queue empty");
        else begin
            e = exp_q.pop_front();
            if ({rsp_valid[1], rsp_err, rsp_zero, rsp_result} !== e) $display("FAIL bp_rsp got=%h exp=%h", {rsp_valid[1], rsp_err, rsp_zero, rsp_result}, e); else n_pass++;
        end
        rsp_ready = 2'b01;
        tick();
        n_checks++; if (rsp_valid !== 2'b10) $display("FAIL bp_wrong_ack got=%b exp=10", rsp_valid); else n_pass++;
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00; #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL bp_next_grant got=%b exp=01", req_ready); else n_pass++;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd2});
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_sb2 queue empty");
        else begin
            e = exp_q.pop_front();
            if ({rsp_valid[1], rsp_err, rsp_zero, rsp_result} !== e) $display("FAIL bp_rsp2 got=%h exp=%h", {rsp_valid[1], rsp_err, rsp_zero, rsp_result}, e); else n_pass++;
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_illegal();
        logic [W-1:0] e;
        pulse_reset();
        set_req(0, 4'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        req_valid = 2'b01; #1;
        n_checks++; if (req_ready !== 2'b01 || alu_ctrl !== 4'd3) $display("FAIL illegal_pass_op got=%b/%0d exp=01/3", req_ready, alu_ctrl); else n_pass++;
        exp_q.push_back({1'b0, 1'b1, 1'b1, 32'd0});
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL illegal_sb queue empty");
        else begin
            e = exp_q.pop_front();
            if ({rsp_valid, rsp_err, rsp_zero, rsp_result} !== {2'b01, e[W-2:0]}) $display("FAIL illegal_rsp got=%b/%h exp=01/%h", rsp_valid, {rsp_err, rsp_zero, rsp_result}, e[W-2:0]); else n_pass++;
        end
        n_checks++; if (dbg_prio !== 1'b1) $display("FAIL illegal_prio got=%b exp=1", dbg_prio); else n_pass++;
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
        set_req(0, 4'd2, 32'd1, 32'd2, 5'd0);
        set_req(1, 4'd1, 32'h10, 32'h01, 5'd0);
        req_valid = 2'b11; #1;
        n_checks++; if (req_ready !== 2'b10) $display("FAIL illegal_next_grant got=%b exp=10", req_ready); else n_pass++;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 32'h11});
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL illegal_sb2 queue empty");
        else begin
            e = exp_q.pop_front();
            if ({rsp_valid[1], rsp_err, rsp_zero, rsp_result} !== e) $display("FAIL illegal_rsp2 got=%h exp=%h", {rsp_valid[1], rsp_err, rsp_zero, rsp_result}, e); else n_pass++;
        end
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] e;
        set_req(1, 4'd2, 32'd100, 32'd23, 5'd0);
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        n_checks++; if (rsp_valid !== 2'b10) $display("FAIL rmid_pre got=%b exp=10", rsp_valid); else n_pass++;
        reset = 1'b1;
        set_req(0, 4'd2, 32'd3, 32'd4, 5'd0);
        req_valid = 2'b11;
        tick();
        n_checks++; if ({rsp_valid, rsp_result} !== {2'b00, 32'd0}) $display("FAIL rmid_clear got=%b/%h exp=00/0", rsp_valid, rsp_result); else n_pass++;
        n_checks++; if (dbg_state !== ST_IDLE || req_ready !== 2'b00) $display("FAIL rmid_idle got=%b/%b exp=IDLE/00", dbg_state, req_ready); else n_pass++;
        exp_q.delete();
        reset = 1'b0; #1;
        n_checks++; if (req_ready !== 2'b01) $display("FAIL rmid_first_grant got=%b exp=01", req_ready); else n_pass++;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 32'd7});
        tick();
        req_valid = 2'b00;
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rmid_sb queue empty");
        else begin
            e = exp_q.pop_front();
            if ({rsp_valid[1], rsp_err, rsp_zero, rsp_result} !== e) $display("FAIL rmid_rsp got=%h exp=%h", {rsp_valid[1], rsp_err, rsp_zero, rsp_result}, e); else n_pass++;
        end
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;
    endtask

    task automatic test_nor_and();
        logic [W-1:0]     e;
        logic [3:0]       ops[2];
        logic [WIDTH-1:0] as[2];
        logic [WIDTH-1:0] bs[2];
        logic [WIDTH-1:0] rs[2];
        ops = '{4'd12, 4'd0};
        as  = '{32'd0, 32'h0000_F0F0};
        bs  = '{32'd0, 32'h0000_0FF0};
        rs  = '{32'hFFFF_FFFF, 32'h0000_00F0};
        for (int k = 0; k < 2; k++) begin
            set_req(1, ops[k], as[k], bs[k], 5'd0);
            req_valid = 2'b10; #1;
            n_checks++; if (req_ready !== 2'b10) $display("FAIL logic%0d_grant got=%b exp=10", k, req_ready); else n_pass++;
            exp_q.push_back({1'b1, 1'b0, 1'b0, rs[k]});
            tick();
            req_valid = 2'b00;
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL logic%0d_sb queue empty", k);
            else begin
                e = exp_q.pop_front();
                if ({rsp_valid, rsp_err, rsp_zero, rsp_result} !== {2'b10, e[W-2:0]}) $display("FAIL logic%0d_rsp got=%b/%h exp=10/%h", k, rsp_valid, {rsp_err, rsp_zero, rsp_result}, e[W-2:0]); else n_pass++;
            end
            rsp_ready = 2'b10;
            tick();
            rsp_ready = 2'b00;
        end
    endtask

    task automatic test_random();
        logic [W-1:0]     e;
        logic [3:0]       op_pool[9];
        logic [3:0]       op_r[2];
        logic [WIDTH-1:0] a_r[2];
        logic [WIDTH-1:0] b_r[2];
        logic [4:0]       sh_r[2];
        logic [WIDTH-1:0] res;
        logic [1:0]       rv;
        logic             g;
        logic             m_prio;
        op_pool = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12, 4'd13, 4'd3, 4'd15};
        pulse_reset();
        m_prio = 1'b0;
        for (int k = 0; k < 12; k++) begin
            for (int r = 0; r < 2; r++) begin
                op_r[r] = op_pool[$urandom_range(0, 8)];
                a_r[r]  = $urandom;
                b_r[r]  = (k < 2) ? a_r[r] : $urandom;
                sh_r[r] = 5'($urandom_range(0, 31));
                set_req(r[0], op_r[r], a_r[r], b_r[r], sh_r[r]);
            end
            rv = 2'($urandom_range(1, 3));
            g  = (rv == 2'b11) ? m_prio : rv[1];
            req_valid = rv; #1;
            n_checks++; if (req_ready !== (g ? 2'b10 : 2'b01)) $display("FAIL rand%0d_grant got=%b exp=%b", k, req_ready, g ? 2'b10 : 2'b01); else n_pass++;
            res = alu_fn(op_r[g], a_r[g], b_r[g], sh_r[g]);
            exp_q.push_back({g, !bench_legal(op_r[g]), res == '0, res});
            m_prio = ~g;
            tick();
            req_valid = 2'b00;
            repeat ($urandom_range(0, 3)) tick();
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL rand%0d_sb queue empty", k);
            else begin
                e = exp_q.pop_front();
                if ({rsp_valid, rsp_err, rsp_zero, rsp_result} !== {(g ? 2'b10 : 2'b01), e[W-2:0]}) $display("FAIL rand%0d_rsp got=%b/%h exp=%b/%h", k, rsp_valid, {rsp_err, rsp_zero, rsp_result}, g ? 2'b10 : 2'b01, e[W-2:0]); else n_pass++;
            end
            rsp_ready = g ? 2'b10 : 2'b01;
            tick();
            rsp_ready = 2'b00;
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
        set_req(0, 4'd0, '0, '0, 5'd0);
        set_req(1, 4'd0, '0, '0, 5'd0);
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_nor_and();
        test_random();
        n_checks++; if (exp_q.size() != 0) $display("FAIL sb_drain got=%0d exp=0", exp_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
